// File: rtl/jam_cost_table.sv
// Cost table for the job-assignment engine: a 64-entry row-major load, then
// zero-latency (W,J) lookup while the engine runs, until it reports a result.
module jam_cost_table (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        in_valid,
  input  logic [6:0]  in_data,
  output logic        in_ready,
  input  logic        new_set,
  input  logic [2:0]  W,
  input  logic [2:0]  J,
  output logic [6:0]  Cost,
  output logic        jam_rst,
  input  logic        jam_valid,
  output logic [12:0] checksum,
  output logic [15:0] read_count,
  output logic        done
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  addr_q, addr_d;
  logic [12:0] checksum_q, checksum_d;
  logic [15:0] read_count_q, read_count_d;
  logic [6:0]  mem_q [64];
  logic        accept;

  // new_set wins over a coincident beat, so that beat is neither written nor summed
  assign accept = (state_q == LOAD) && in_valid && !new_set;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    checksum_d   = checksum_q;
    read_count_d = read_count_q;
    if (new_set) begin
      state_d      = LOAD;
      addr_d       = '0;
      checksum_d   = '0;
      read_count_d = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            addr_d     = addr_q + 6'd1;
            checksum_d = checksum_q + {6'b0, in_data};
            if (addr_q == 6'd63) state_d = SERVE;
          end
        end
        SERVE: begin
          if (read_count_q != '1) read_count_d = read_count_q + 16'd1;
          if (jam_valid) state_d = DONE;
        end
        DONE:    state_d = DONE;
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= LOAD;
      addr_q       <= '0;
      checksum_q   <= '0;
      read_count_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      checksum_q   <= checksum_d;
      read_count_q <= read_count_d;
    end
  end

  // Table storage is deliberately not reset; Cost is gated to SERVE so stale data never leaks
  always_ff @(posedge CLK) begin
    if (accept) mem_q[addr_q] <= in_data;
  end

  assign in_ready   = (state_q == LOAD);
  assign jam_rst    = (state_q == LOAD);
  assign done       = (state_q == DONE);
  assign Cost       = (state_q == SERVE) ? mem_q[{W, J}] : '0;
  assign checksum   = checksum_q;
  assign read_count = read_count_q;

endmodule

// File: doc/jam_cost_table.md
JAM_COST_TABLE -- requirements
Module: jam_cost_table

Interface
REQ-001 SHALL: CLK  input  1  rising-edge clock for all state.
REQ-002 SHALL: RST_N  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL: in_valid  input  1  load beat valid.
REQ-004 SHALL: in_data  input  7  load beat cost value, unsigned.
REQ-005 SHALL: in_ready  output  1  load beat accepted when in_valid && in_ready at a CLK edge.
REQ-006 SHALL: new_set  input  1  single-cycle request to discard the table and start a new load.
REQ-007 SHALL: W  input  3  worker index from the assignment engine.
REQ-008 SHALL: J  input  3  job index from the assignment engine.
REQ-009 SHALL: Cost  output  7  cost of (W,J), returned to the assignment engine.
REQ-010 SHALL: jam_rst  output  1  active-high reset driven to the assignment engine.
REQ-011 SHALL: jam_valid  input  1  assignment engine result-valid (Valid).
REQ-012 SHALL: checksum  output  13  sum of all accepted load beats of the current set.
REQ-013 SHALL: read_count  output  16  SERVE-state cycle counter, saturating.
REQ-014 SHALL: done  output  1  high in DONE state.

Function
REQ-015 SHALL: storage is 64 x 7-bit entries, addressed {W,J} (W = bits 5:3, J = bits 2:0).
REQ-016 SHALL: states are LOAD, SERVE and DONE, with 2-bit encoding.
REQ-017 SHALL: LOAD behaviour -- in_ready=1 and jam_rst=1; each accepted beat writes entry[addr] and then increments the 6-bit addr; row-major order, so beat n maps to W=n/8, J=n%8.
REQ-018 SHALL: LOAD behaviour -- each accepted beat adds zero-extended in_data to checksum; the width is 13 bits and the maximum is 64*127=8128, so there is no overflow.
REQ-019 SHALL: LOAD exits to SERVE on the edge that accepts beat 64 (addr 63); that beat is written and summed.
REQ-020 SHALL: in_valid while in_ready=0 is ignored; no write, no checksum change.
REQ-021 SHALL: SERVE behaviour -- in_ready=0 and jam_rst=0; Cost = entry[{W,J}] combinationally, with zero cycles of latency, so the value is valid in the same cycle W/J change.
REQ-022 SHALL: in LOAD and DONE, Cost = 0.
REQ-023 SHALL: SERVE behaviour -- read_count increments once per SERVE cycle and saturates at 65535.
REQ-024 SHALL: SERVE exits to DONE when jam_valid=1 is sampled.
REQ-025 SHALL: DONE behaviour -- done=1 and jam_rst=0, so engine outputs are held; the table and checksum are retained.
REQ-026 SHALL: new_set=1 in any state moves to LOAD on the next edge and clears addr, checksum and read_count; table contents are not cleared, because they are overwritten by the load.
REQ-027 SHALL: new_set has priority over jam_valid and over a simultaneous load beat; that beat is not written and not summed.
REQ-028 SHALL: new_set asserted in LOAD mid-load restarts the load at addr 0.
REQ-029 SHALL: jam_valid outside SERVE is ignored.

Reset
REQ-030 SHALL: RST_N=0 asynchronously forces state=LOAD, addr=0, checksum=0 and read_count=0.
REQ-031 SHALL: while RST_N=0, outputs are in_ready=1, jam_rst=1, done=0 and Cost=0.
REQ-032 SHALL: table contents are not reset and are unspecified until a full load completes; they are never observable on Cost before that.
REQ-033 SHALL: reset asserted mid-load or mid-SERVE aborts the operation; a full 64-beat load is required afterwards.

Verification
REQ-034 SHALL: scenario "full load". Stimulus -- 64 beats with in_data=n%128 for n=0..63, in_valid held high. Required response -- SERVE entered after beat 64; checksum=2016; jam_rst falls on the same edge.
REQ-035 SHALL: scenario "readback". Stimulus -- in SERVE, drive W=5, J=3. Required response -- Cost=43 in the same cycle; W=7, J=7 gives Cost=63.
REQ-036 SHALL: scenario "backpressure/gaps". Stimulus -- in_valid toggled 1,0,0,1 during the load. Required response -- only valid beats are counted; SERVE is entered after exactly 64 accepted beats.
REQ-037 SHALL: scenario "completion". Stimulus -- jam_valid=1 after 100 SERVE cycles. Required response -- done=1; read_count=100; Cost=0 in DONE.
REQ-038 SHALL: scenario "new_set priority". Stimulus -- new_set and jam_valid together in SERVE. Required response -- LOAD is entered, not DONE; checksum=0; read_count=0; jam_rst=1.
REQ-039 SHALL: scenario "reset mid-load". Stimulus -- RST_N low after 30 beats, then a reload of 64 beats of value 127. Required response -- checksum=8128; every (W,J) reads 127.
